cbus_arbiter: RTL and testbench
===============================

# cbus_arbiter

Multi-port cache-bus arbiter that merges N independent `cbus_req_t` requesters (instruction fetch, data access, uncached path) into the single `cbus_req_t`/`cbus_resp_t` pair consumed by `CBusToAXI` in the AXI build of `mycpu_top`. It grants one whole transaction (single beat or burst) at a time, forwards the winner's request unchanged and routes the response back to that requester only. Arbitration is fixed-priority or round-robin, chosen by parameter.

## Interface

- `NUM_INPUTS`, default 2: number of requester ports; index 0 is highest priority in fixed mode.
- `ROUND_ROBIN`, default 0: 0 = fixed priority, 1 = round-robin starting after the last granted index.
- `clk`  in  1  core clock.
- `resetn`  in  1  reset. One clock; reset is synchronous and active-low.
- `ireqs`  in  `cbus_req_t [NUM_INPUTS]`  requester-side requests (`valid`, `is_write`, `size`, `addr`, `strobe`, `data`, `len`).
- `iresps`  out  `cbus_resp_t [NUM_INPUTS]`  per-requester responses (`ready`, `last`, `data`).
- `oreq`  out  `cbus_req_t`  request to `CBusToAXI`.
- `oresp`  in  `cbus_resp_t`  response from `CBusToAXI`.

## Operation

- State: `busy` (1 bit), `index` (clog2(NUM_INPUTS) bits, min 1), `last_grant` (same width, round-robin only).
- IDLE (`busy`=0):
  - `oreq` is all-zero; every `iresps[i]` is all-zero.
  - If any `ireqs[i].valid`, select a winner: fixed mode picks the lowest valid index; round-robin mode picks the first valid index scanning from `last_grant+1` upward, modulo NUM_INPUTS.
  - Register `index <= winner` and `busy <= 1`.
- BUSY (`busy`=1):
  - `oreq = ireqs[index]`, combinational pass-through with all fields unmodified.
  - `iresps[index] = oresp`; all other `iresps[j]` are all-zero (`ready`=0).
  - Requests arriving on other ports wait; they are not dropped or latched.
  - On `oresp.ready && oresp.last`: `busy <= 0`, `last_grant <= index`.
  - The grant is locked until that last beat. If the granted requester drops `valid` early (a protocol violation), the arbiter stays BUSY and forwards `valid`=0.
- Requesters must deassert `valid` or present a new request after receiving `last`. The arbiter re-arbitrates from IDLE and never chains grants back-to-back.
- NUM_INPUTS=1 degenerates to a registered-grant pass-through with the same timing.

## Timing

- Reset (`resetn`=0 at a rising edge): next cycle `busy`=0, `index`=0, `last_grant`=NUM_INPUTS-1 (so round-robin first favours port 0), `oreq`/`iresps` all-zero. Reset mid-burst aborts the grant without waiting for `last`.
- Grant latency: a `valid` seen in cycle t appears on `oreq.valid` in cycle t+1.
- Response latency: zero cycles. `oresp` reaches `iresps[index]` in the same cycle.
- Release: the last-beat handshake in cycle t gives IDLE in t+1 and earliest next `oreq.valid` in t+2.
- Turnaround: one idle bus cycle between consecutive transactions.
- Simultaneous requests in the same cycle are resolved purely by the priority rule. A request arriving while BUSY is evaluated in the first IDLE cycle.
- No combinational path from `ireqs` to `busy`/`index` bypasses the register. `oreq` depends combinationally on `ireqs` only through the registered `index`.

## Test plan

- **Single request:** port1 issues a read at `addr`=0x1fc0_0000, `len`=single; `oresp` gives `ready`=`last`=1 with `data`=0xdeadbeef in cycle 3. Required: `oreq.valid` from cycle 1; `iresps[1].data`=0xdeadbeef in cycle 3; `iresps[0].ready`=0 throughout; IDLE in cycle 4.
- **Simultaneous, fixed priority:** ports 0 and 1 valid in the same cycle. Required: port 0 granted first; port 1 granted two cycles after port 0's last beat.
- **Round-robin:** with ROUND_ROBIN=1, ports 0 and 1 request continuously for 4 transactions. Required: grant order 0,1,0,1.
- **Burst lock:** port 0 runs a 4-beat read burst while port 1 requests at beat 2. Required: `oreq` stays equal to `ireqs[0]` until beat 4 `last`; port 1 receives no `ready`.
- **Write pass-through:** port 1 writes `strobe`=4'b0011, `data`=0x1234_5678. Required: identical `is_write`/`strobe`/`data`/`size` appear on `oreq`.
- **Reset mid-burst:** assert `resetn`=0 during beat 2 of a burst. Required: the next cycle has `oreq.valid`=0 and all `iresps` zero; after release, port 0 is granted first in round-robin mode.

Source files
------------

// File: rtl/cbus_arbiter_if.sv
// Cache-bus request/response types and the bundled port interface used by
// cbus_arbiter: requester-side arrays plus the single downstream request/response pair.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

interface cbus_arbiter_if #(
  parameter int NUM_INPUTS = 2
);
  import cbus_pkg::*;

  cbus_req_t  ireqs  [NUM_INPUTS];
  cbus_resp_t iresps [NUM_INPUTS];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  // Arbiter side: consumes requests and the downstream response.
  modport slave (
    input  ireqs,
    input  oresp,
    output iresps,
    output oreq
  );

  // Environment side: requesters plus the downstream bridge.
  modport master (
    output ireqs,
    output oresp,
    input  iresps,
    input  oreq
  );

endinterface

// File: rtl/cbus_arbiter.sv
// Cache-bus arbiter: grants one whole transaction at a time to one of NUM_INPUTS
// requesters, forwards its request unchanged and routes the response to it only.
module cbus_arbiter_chk #(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_W      = 1
) (
  input logic                  clk,
  input logic                  resetn,
  input logic                  busy,
  input logic [IDX_W-1:0]      index,
  input logic                  oreq_valid,
  input logic [NUM_INPUTS-1:0] ready_vec,
  input logic                  done
);

  a_idle_quiet: assert property (@(posedge clk) disable iff (!resetn)
    !busy |-> (!oreq_valid && (ready_vec == '0)));

  a_one_ready: assert property (@(posedge clk) disable iff (!resetn)
    $onehot0(ready_vec));

  a_grant_lock: assert property (@(posedge clk) disable iff (!resetn)
    (busy && !done) |=> (busy && $stable(index)));

  a_index_range: assert property (@(posedge clk) disable iff (!resetn)
    busy |-> (int'(index) < NUM_INPUTS));

endmodule

module cbus_arbiter #(
  parameter int NUM_INPUTS  = 2,
  parameter int ROUND_ROBIN = 0
) (
  input  logic          clk,
  input  logic          resetn,
  cbus_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Reset points last_grant at the top port so round-robin favours port 0 first.
  localparam idx_t LAST_GRANT_RST = idx_t'(NUM_INPUTS - 1);

  state_t                state_r;
  state_t                state_s;
  idx_t                  index_r;
  idx_t                  index_s;
  idx_t                  last_grant_r;
  idx_t                  last_grant_s;
  idx_t                  winner_s;
  logic                  found_s;
  logic                  done_s;
  logic                  busy_s;
  logic [NUM_INPUTS-1:0] ready_vec_s;

  assign busy_s = (state_r == ST_BUSY);
  assign done_s = bus.oresp.ready && bus.oresp.last;

  // Priority scan; round-robin starts just past the last granted port.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      int   cand;
      logic hit;
      if (ROUND_ROBIN != 0) begin
        cand = (int'(last_grant_r) + k + 1) % NUM_INPUTS;
      end else begin
        cand = k;
      end
      hit      = bus.ireqs[cand].valid && !found_s;
      winner_s = hit ? idx_t'(cand) : winner_s;
      found_s  = found_s || hit;
    end
  end

  // Next state: arbitrate only from IDLE, hold the grant until the last-beat handshake.
  always_comb begin
    state_s      = state_r;
    index_s      = index_r;
    last_grant_s = last_grant_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_s = ST_BUSY;
          index_s = winner_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done_s) begin
          state_s      = ST_IDLE;
          last_grant_s = index_r;
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Grant registers; reset aborts any grant in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      index_r      <= '0;
      last_grant_r <= LAST_GRANT_RST;
    end else begin
      state_r      <= state_s;
      index_r      <= index_s;
      last_grant_r <= last_grant_s;
    end
  end

  // Forward the granted request and steer the response to its owner only.
  always_comb begin
    bus.oreq = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      bus.iresps[i] = '0;
    end
    if (busy_s) begin
      bus.oreq            = bus.ireqs[index_r];
      bus.iresps[index_r] = bus.oresp;
    end else begin
      bus.oreq = '0;
    end
  end

  // Gather per-port ready bits for the checker.
  always_comb begin
    ready_vec_s = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      ready_vec_s[i] = bus.iresps[i].ready;
    end
  end

  cbus_arbiter_chk #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_W      (IDX_W)
  ) u_chk (
    .clk        (clk),
    .resetn     (resetn),
    .busy       (busy_s),
    .index      (index_r),
    .oreq_valid (bus.oreq.valid),
    .ready_vec  (ready_vec_s),
    .done       (done_s)
  );

endmodule

// File: tb/tb_cbus_arbiter.sv
// Randomized bench for cbus_arbiter: a fixed-priority and a round-robin instance share
// stimulus and are compared each cycle against a transaction-level reference model.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N = 3;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cbus_arbiter_if #(.NUM_INPUTS(N)) bus_fx ();
  cbus_arbiter_if #(.NUM_INPUTS(N)) bus_rr ();

  cbus_arbiter #(.NUM_INPUTS(N), .ROUND_ROBIN(0)) u_fx (.clk(clk), .resetn(resetn), .bus(bus_fx.slave));
  cbus_arbiter #(.NUM_INPUTS(N), .ROUND_ROBIN(1)) u_rr (.clk(clk), .resetn(resetn), .bus(bus_rr.slave));

  cbus_req_t  tmpl    [N];
  logic       pending [N];
  cbus_req_t  req_s   [N];
  cbus_resp_t resp_s;
  int         react_dut = -1;

  // Reference model: per instance, who owns the bus and who was served last.
  bit m_init = 1'b0;
  bit m_busy  [2];
  int m_owner [2];
  int m_last  [2];

  cbus_req_t  snap_oreq [2];
  cbus_resp_t snap_resp [2][N];
  int log_fx[$];
  int log_rr[$];
  int cyc_fx[$];
  int cyc_rr[$];
  int cyc = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic cbus_req_t dut_oreq(input int d);
    return (d == 0) ? bus_fx.oreq : bus_rr.oreq;
  endfunction

  function automatic cbus_resp_t dut_resp(input int d, input int j);
    return (d == 0) ? bus_fx.iresps[j] : bus_rr.iresps[j];
  endfunction

  function automatic int pick(input bit rr, input int last);
    if (rr) begin
      for (int s = 1; s <= N; s++) begin
        if (req_s[(last + s) % N].valid) return (last + s) % N;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        if (req_s[c].valid) return c;
      end
    end
    return -1;
  endfunction

  function automatic cbus_req_t rand_req();
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = 1'($urandom_range(0, 1));
    r.size     = 3'($urandom_range(0, 7));
    r.addr     = $urandom;
    r.strobe   = 4'($urandom_range(0, 15));
    r.data     = $urandom;
    r.len      = 4'($urandom_range(0, 15));
    return r;
  endfunction

  task automatic apply();
    for (int p = 0; p < N; p++) begin
      req_s[p]       = tmpl[p];
      req_s[p].valid = pending[p];
      bus_fx.ireqs[p] = req_s[p];
      bus_rr.ireqs[p] = req_s[p];
    end
    bus_fx.oresp = resp_s;
    bus_rr.oresp = resp_s;
  endtask

  task automatic tick();
    cbus_req_t  exp_req;
    cbus_resp_t exp_resp;
    int         w;
    apply();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      snap_oreq[d] = dut_oreq(d);
      for (int j = 0; j < N; j++) snap_resp[d][j] = dut_resp(d, j);
      if (m_init) begin
        exp_req = m_busy[d] ? req_s[m_owner[d]] : '0;
        check_eq($sformatf("%s_oreq c%0d", (d == 0) ? "fx" : "rr", cyc), 128'(snap_oreq[d]), 128'(exp_req));
        for (int j = 0; j < N; j++) begin
          exp_resp = (m_busy[d] && (m_owner[d] == j)) ? resp_s : '0;
          check_eq($sformatf("%s_iresp%0d c%0d", (d == 0) ? "fx" : "rr", j, cyc),
                   128'(snap_resp[d][j]), 128'(exp_resp));
        end
      end
      for (int j = 0; j < N; j++) begin
        if (snap_resp[d][j].ready && snap_resp[d][j].last) begin
          if (d == 0) begin log_fx.push_back(j); cyc_fx.push_back(cyc); end
          else        begin log_rr.push_back(j); cyc_rr.push_back(cyc); end
        end
      end
    end
    if (react_dut >= 0) begin
      for (int p = 0; p < N; p++) begin
        if (snap_resp[react_dut][p].ready && snap_resp[react_dut][p].last) pending[p] = 1'b0;
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!resetn) begin
        m_busy[d]  = 1'b0;
        m_owner[d] = 0;
        m_last[d]  = N - 1;
      end else if (m_init) begin
        if (!m_busy[d]) begin
          w = pick(d == 1, m_last[d]);
          if (w >= 0) begin
            m_busy[d]  = 1'b1;
            m_owner[d] = w;
          end
        end else if (resp_s.ready && resp_s.last) begin
          m_busy[d] = 1'b0;
          m_last[d] = m_owner[d];
        end
      end
    end
    if (!resetn) m_init = 1'b1;
    cyc++;
    #1;
  endtask

  task automatic clear_logs();
    log_fx.delete(); log_rr.delete(); cyc_fx.delete(); cyc_rr.delete();
  endtask

  function automatic int qget(input int q[$], input int k);
    return (q.size() > k) ? q[k] : -1;
  endfunction

  initial begin
    int rr_exp [4] = '{0, 1, 0, 1};
    int gap;
    cbus_req_t wr;

    for (int p = 0; p < N; p++) begin
      tmpl[p]    = '0;
      pending[p] = 1'b0;
    end
    resp_s = '0;

    // Reset and idle state
    resetn = 1'b0; tick(); tick(); resetn = 1'b1;
    tick();
    check_eq("reset_fx_oreq", 128'(snap_oreq[0]), 128'(0));
    check_eq("reset_rr_oreq", 128'(snap_oreq[1]), 128'(0));

    // Single read on port 1
    react_dut = 0;
    tmpl[1] = '{valid: 1'b1, is_write: 1'b0, size: 3'd2, addr: 32'h1fc0_0000,
                strobe: 4'h0, data: 32'h0, len: 4'd0};
    pending[1] = 1'b1;
    tick();
    tick();
    check_eq("single_grant", 128'(snap_oreq[0].valid), 128'(1'b1));
    tick();
    resp_s = '{ready: 1'b1, last: 1'b1, data: 32'hdeadbeef};
    tick();
    check_eq("single_data", 128'(snap_resp[0][1].data), 128'(32'hdeadbeef));
    check_eq("single_p0_ready", 128'(snap_resp[0][0].ready), 128'(1'b0));
    resp_s = '0;
    tick();
    check_eq("single_idle", 128'(snap_oreq[0].valid), 128'(1'b0));

    // Simultaneous requests, fixed priority
    clear_logs();
    tmpl[0] = rand_req(); tmpl[0].len = 4'd0;
    tmpl[1] = rand_req(); tmpl[1].len = 4'd0;
    pending[0] = 1'b1; pending[1] = 1'b1;
    resp_s = '{ready: 1'b1, last: 1'b1, data: $urandom};
    repeat (6) tick();
    check_eq("fixed_count", 128'(log_fx.size()), 128'(2));
    check_eq("fixed_first", 128'(qget(log_fx, 0)), 128'(0));
    check_eq("fixed_second", 128'(qget(log_fx, 1)), 128'(1));
    gap = (cyc_fx.size() > 1) ? (cyc_fx[1] - cyc_fx[0]) : -1;
    check_eq("fixed_gap", 128'(gap), 128'(2));

    // Continuous requests: round-robin alternates, fixed keeps port 0
    for (int p = 0; p < N; p++) pending[p] = 1'b0;
    resetn = 1'b0; tick(); resetn = 1'b1;
    clear_logs();
    react_dut = -1;
    pending[0] = 1'b1; pending[1] = 1'b1;
    resp_s = '{ready: 1'b1, last: 1'b1, data: $urandom};
    repeat (8) tick();
    check_eq("rr_count", 128'(log_rr.size()), 128'(4));
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("rr_order%0d", k), 128'(qget(log_rr, k)), 128'(rr_exp[k]));
      check_eq($sformatf("fx_order%0d", k), 128'(qget(log_fx, k)), 128'(0));
    end
    pending[0] = 1'b0; pending[1] = 1'b0;
    resp_s = '0;
    repeat (2) tick();

    // Burst lock: port 0 four-beat burst, port 1 arrives at beat 2
    clear_logs();
    react_dut = 0;
    tmpl[0] = rand_req(); tmpl[0].is_write = 1'b0; tmpl[0].len = 4'd3;
    tmpl[1] = rand_req(); tmpl[1].len = 4'd0;
    pending[0] = 1'b1;
    tick();
    for (int b = 1; b <= 4; b++) begin
      resp_s = '{ready: 1'b1, last: (b == 4), data: $urandom};
      if (b == 2) pending[1] = 1'b1;
      tick();
      check_eq($sformatf("burst_p1_ready b%0d", b), 128'(snap_resp[0][1].ready), 128'(1'b0));
      check_eq($sformatf("burst_lock b%0d", b), 128'(snap_oreq[0]), 128'(tmpl[0]));
    end
    resp_s = '{ready: 1'b1, last: 1'b1, data: $urandom};
    repeat (3) tick();
    check_eq("burst_order0", 128'(qget(log_fx, 0)), 128'(0));
    check_eq("burst_order1", 128'(qget(log_fx, 1)), 128'(1));
    gap = (cyc_fx.size() > 1) ? (cyc_fx[1] - cyc_fx[0]) : -1;
    check_eq("burst_gap", 128'(gap), 128'(2));

    // Write pass-through on port 1
    for (int p = 0; p < N; p++) pending[p] = 1'b0;
    resp_s = '0;
    tick();
    wr = '{valid: 1'b1, is_write: 1'b1, size: 3'd2, addr: $urandom,
           strobe: 4'b0011, data: 32'h1234_5678, len: 4'd0};
    tmpl[1] = wr;
    pending[1] = 1'b1;
    tick();
    tick();
    check_eq("write_pass_fx", 128'(snap_oreq[0]), 128'(wr));
    check_eq("write_pass_rr", 128'(snap_oreq[1]), 128'(wr));
    resp_s = '{ready: 1'b1, last: 1'b1, data: $urandom};
    tick();
    resp_s = '0;
    tick();

    // Reset in the middle of a round-robin burst on port 2
    react_dut = 1;
    tmpl[2] = rand_req(); tmpl[2].len = 4'd3;
    pending[2] = 1'b1;
    tick();
    resp_s = '{ready: 1'b1, last: 1'b0, data: $urandom};
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    clear_logs();
    pending[0] = 1'b1; pending[1] = 1'b1;
    resp_s = '{ready: 1'b1, last: 1'b1, data: $urandom};
    tick();
    check_eq("rst_rr_oreq_valid", 128'(snap_oreq[1].valid), 128'(1'b0));
    for (int j = 0; j < N; j++) begin
      check_eq($sformatf("rst_rr_iresp%0d", j), 128'(snap_resp[1][j]), 128'(0));
    end
    repeat (2) tick();
    check_eq("rr_after_reset", 128'(qget(log_rr, 0)), 128'(0));

    // Random traffic against the model
    react_dut = -1;
    repeat (3000) begin
      for (int p = 0; p < N; p++) begin
        tmpl[p]    = rand_req();
        pending[p] = ($urandom_range(0, 99) < 55);
      end
      resp_s.ready = ($urandom_range(0, 9) < 6);
      resp_s.last  = ($urandom_range(0, 9) < 4);
      resp_s.data  = $urandom;
      resetn       = ($urandom_range(0, 199) != 0);
      tick();
    end
    resetn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
